// File: rtl/jtframe_arb_pkg.sv
// Shared types and helpers for the ROM bank arbiter: FSM states, arbitration
// mode codes and the index-width function.
package jtframe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } arb_st_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a client index; never narrower than one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/jtframe_rom_arb_if.sv
// Read-only SDRAM bank port as seen by the arbiter (master) and the SDRAM
// controller (slave).
interface jtframe_rom_arb_if #(
  parameter int AW = 22,
  parameter int DW = 32
);
  // Handshake: the master raises ba_rd with ba_addr and holds both steady until
  // it samples ba_ack high; ba_rd drops the cycle after. Later, ba_rdy marks the
  // single cycle in which sdram_dout carries the read data.
  logic [AW-1:0] ba_addr;
  logic          ba_rd;
  logic          ba_ack;
  logic          ba_rdy;
  logic [DW-1:0] sdram_dout;

  modport master (output ba_addr, ba_rd, input ba_ack, ba_rdy, sdram_dout);
  modport slave  (input ba_addr, ba_rd, output ba_ack, ba_rdy, sdram_dout);
endinterface

// File: rtl/jtframe_arb_pick.sv
// Combinational request picker: fixed priority (lowest index) or round-robin
// starting at the rr pointer.
module jtframe_arb_pick
  import jtframe_arb_pkg::*;
#(
  parameter int CLIENTS = 4,
  parameter int SW      = clog2w(CLIENTS)
) (
  input  logic [CLIENTS-1:0] req_i,
  input  logic [SW-1:0]      rr_i,
  input  logic               mode_i,
  output logic [SW-1:0]      sel_o,
  output logic               any_o
);

  int idx;

  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int k = 0; k < CLIENTS; k++) begin
      idx = mode_i ? (int'(rr_i) + k) % CLIENTS : k;
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        sel_o = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// N-client read arbiter for one SDRAM bank with a one-entry cache per client;
// repeated addresses are served without touching the SDRAM.
module jtframe_rom_arb
  import jtframe_arb_pkg::*;
#(
  parameter int CLIENTS = 4,
  parameter int AW      = 22,
  parameter int DW      = 32,
  parameter int MODE    = 1
) (
  input  logic                  clk_rom,
  input  logic                  rst_n,
  input  logic [CLIENTS-1:0]    cs,
  input  logic [CLIENTS*AW-1:0] addr,
  output logic [CLIENTS-1:0]    ok,
  output logic [CLIENTS*DW-1:0] dout,
  input  logic                  inval,
  jtframe_rom_arb_if.master     ba,
  output arb_st_t               st_dbg_o
);

  localparam int SW = clog2w(CLIENTS);

  arb_st_t            st_q;
  logic [SW-1:0]      sel_q, rr_q, rr_nx, pick_sel;
  logic               pick_any, drop_q, ba_rd_q;
  logic [AW-1:0]      lat_addr_q, ba_addr_q, pick_addr;
  logic [AW-1:0]      tag_q  [CLIENTS];
  logic [DW-1:0]      data_q [CLIENTS];
  logic [CLIENTS-1:0] valid_q, hit, miss;
  logic               done, fill;

  always_comb begin
    hit  = '0;
    dout = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      hit[i]           = cs[i] & valid_q[i] & (tag_q[i] == addr[i*AW +: AW]);
      dout[i*DW +: DW] = data_q[i];
    end
  end

  assign miss = cs & ~hit;
  assign ok   = hit;

  jtframe_arb_pick #(.CLIENTS(CLIENTS), .SW(SW)) u_pick (
    .req_i  (miss),
    .rr_i   (rr_q),
    .mode_i (MODE == ARB_RR),
    .sel_o  (pick_sel),
    .any_o  (pick_any)
  );

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < CLIENTS; i++)
      if (pick_sel == SW'(i)) pick_addr = addr[i*AW +: AW];
  end

  // Ack and rdy in the same WAIT_ACK cycle complete the transfer immediately.
  assign done  = ((st_q == WAIT_ACK) & ba.ba_ack & ba.ba_rdy) |
                 ((st_q == WAIT_RDY) & ba.ba_rdy);
  assign fill  = done & ~drop_q & ~inval;
  assign rr_nx = (sel_q == SW'(CLIENTS-1)) ? '0 : sel_q + SW'(1);

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      sel_q      <= '0;
      rr_q       <= '0;
      drop_q     <= 1'b0;
      ba_rd_q    <= 1'b0;
      ba_addr_q  <= '0;
      lat_addr_q <= '0;
      valid_q    <= '0;
      for (int i = 0; i < CLIENTS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (st_q)
        IDLE: begin
          if (pick_any) begin
            sel_q      <= pick_sel;
            lat_addr_q <= pick_addr;
            ba_addr_q  <= pick_addr;
            ba_rd_q    <= 1'b1;
            st_q       <= WAIT_ACK;
          end else begin
            ba_rd_q <= 1'b0;
          end
        end
        WAIT_ACK: begin
          if (ba.ba_ack) begin
            ba_rd_q <= 1'b0;
            st_q    <= ba.ba_rdy ? IDLE : WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (ba.ba_rdy) st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase

      // Data landing after an invalidate is stale, so it is dropped.
      if (done) begin
        drop_q <= 1'b0;
        rr_q   <= rr_nx;
      end else if (inval && st_q != IDLE) begin
        drop_q <= 1'b1;
      end

      if (inval)     valid_q        <= '0;
      else if (fill) valid_q[sel_q] <= 1'b1;

      if (fill) begin
        data_q[sel_q] <= ba.sdram_dout;
        tag_q[sel_q]  <= lat_addr_q;
      end
    end
  end

  assign ba.ba_rd   = ba_rd_q;
  assign ba.ba_addr = ba_addr_q;
  assign st_dbg_o   = st_q;

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: directed scenarios plus random traffic against a
// transaction-level cache/arbitration model; a MODE 0 instance shows starvation.
module tb_jtframe_rom_arb;
  import jtframe_arb_pkg::*;

  localparam int C  = 4;
  localparam int AW = 22;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (round-robin) ----------------
  logic [C-1:0]    cs = '0;
  logic [C*AW-1:0] addr = '0;
  logic            inval = 1'b0;
  wire  [C-1:0]    ok;
  wire  [C*DW-1:0] dout;
  arb_st_t         st_dbg;
  logic            ack = 1'b0, rdy = 1'b0;
  logic [DW-1:0]   sdout = '0;

  jtframe_rom_arb_if #(.AW(AW), .DW(DW)) bif ();
  assign bif.ba_ack     = ack;
  assign bif.ba_rdy     = rdy;
  assign bif.sdram_dout = sdout;

  jtframe_rom_arb #(.CLIENTS(C), .AW(AW), .DW(DW), .MODE(1)) dut (
    .clk_rom(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .ok(ok), .dout(dout),
    .inval(inval), .ba(bif.master), .st_dbg_o(st_dbg)
  );

  // ---------------- DUT (fixed priority) with an instant controller ----------------
  logic [C-1:0]    f_cs = '0;
  logic [C*AW-1:0] f_addr = '0;
  wire  [C-1:0]    f_ok;
  wire  [C*DW-1:0] f_dout;
  arb_st_t         f_st;
  logic            f_rdy;

  jtframe_rom_arb_if #(.AW(AW), .DW(DW)) fif ();
  assign fif.ba_ack     = fif.ba_rd;
  assign fif.ba_rdy     = f_rdy;
  assign fif.sdram_dout = 32'h1234_5678;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) f_rdy <= 1'b0;
    else        f_rdy <= fif.ba_rd;

  jtframe_rom_arb #(.CLIENTS(C), .AW(AW), .DW(DW), .MODE(0)) fix_dut (
    .clk_rom(clk), .rst_n(rst_n), .cs(f_cs), .addr(f_addr), .ok(f_ok), .dout(f_dout),
    .inval(1'b0), .ba(fif.master), .st_dbg_o(f_st)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0, n_err = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] obs_q[$];

  logic          m_valid [C];
  logic [AW-1:0] m_tag   [C];
  logic [DW-1:0] m_data  [C];
  int            m_rr, m_sel, m_ph, cnt;   // m_ph: 0 no request, 1 awaiting ack, 2 awaiting data
  bit            m_drop;
  logic [AW-1:0] m_lat;
  logic          exp_rd;
  logic [AW-1:0] exp_baddr;
  logic          prev_rd = 1'b0;

  int            ack_dly = 1, rdy_dly = 1;
  bit            noise = 0, rand_dly = 0;
  logic [DW-1:0] rsp_data = 32'h0BAD_F00D;
  int            rr_order [4] = '{0, 2, 3, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_hit(input int i);
    return cs[i] && m_valid[i] && (m_tag[i] == addr[i*AW +: AW]);
  endfunction

  // Round-robin winner: the missing client at the smallest forward distance from rr.
  function automatic int m_pick(input logic [C-1:0] m);
    int best = -1;
    int bd = C;
    for (int i = 0; i < C; i++)
      if (m[i] && ((i - m_rr + C) % C) < bd) begin
        bd   = (i - m_rr + C) % C;
        best = i;
      end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_rr = 0; m_sel = 0; m_ph = 0; cnt = 0; m_drop = 0; m_lat = '0;
    exp_rd = 1'b0; exp_baddr = '0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs present now.
  task automatic model_step();
    logic [C-1:0] miss;
    int  ph0;
    bit  done;
    miss = '0;
    done = 0;
    ph0  = m_ph;
    for (int i = 0; i < C; i++) miss[i] = cs[i] && !m_hit(i);
    case (m_ph)
      0: begin
        if (miss != '0) begin
          m_sel = m_pick(miss);
          m_lat = addr[m_sel*AW +: AW];
          m_ph = 1; cnt = 0;
          exp_rd = 1'b1; exp_baddr = m_lat;
          exp_q.push_back(m_lat);
          if (rand_dly) begin
            ack_dly  = $urandom_range(0, 3);
            rdy_dly  = $urandom_range(0, 3);
            rsp_data = $urandom;
          end
        end else begin
          exp_rd = 1'b0;
        end
      end
      1: begin
        if (ack) begin
          exp_rd = 1'b0;
          if (rdy) done = 1;
          else begin m_ph = 2; cnt = 0; end
        end else cnt++;
      end
      default: begin
        if (rdy) done = 1;
        else cnt++;
      end
    endcase
    if (done) begin
      if (!m_drop && !inval) begin
        m_data[m_sel] = sdout; m_tag[m_sel] = m_lat; m_valid[m_sel] = 1'b1;
      end
      m_drop = 0;
      m_rr = (m_sel + 1) % C;
      m_ph = 0;
    end else if (inval && ph0 != 0) begin
      m_drop = 1;
    end
    if (inval) for (int i = 0; i < C; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < C; i++) begin
      chk($sformatf("ok%0d", i), ok[i], m_hit(i));
      chk($sformatf("dout%0d", i), dout[i*DW +: DW], m_data[i]);
    end
    chk("ba_rd", bif.ba_rd, exp_rd);
    if (exp_rd) chk("ba_addr", bif.ba_addr, exp_baddr);
    if (bif.ba_rd && !prev_rd) begin
      obs_q.push_back(bif.ba_addr);
      if (exp_q.size() == 0) chk("spurious_req", exp_q.size(), 1);
      else chk("req_addr", bif.ba_addr, exp_q.pop_front());
    end
    prev_rd = bif.ba_rd;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bank();
    ack = 1'b0; rdy = 1'b0; sdout = $urandom;
    if (m_ph == 1) begin
      if (cnt >= ack_dly) begin
        ack = 1'b1;
        if (rdy_dly == 0) begin rdy = 1'b1; sdout = rsp_data; end
      end
    end else if (m_ph == 2) begin
      if (cnt >= rdy_dly - 1) begin rdy = 1'b1; sdout = rsp_data; end
    end else if (noise) begin
      ack = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic tick();
    if (rst_n) model_step(); else model_reset();
    @(posedge clk); #1;
    check_outputs();
    drive_bank();
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (m_ph != 0 && n < max) begin tick(); n++; end
    chk("idle_timeout", m_ph, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_ok", ok, 0);
    chk("rst_rd", bif.ba_rd, 0);
    chk("rst_addr", bif.ba_addr, 0);
    chk("rst_dout_zero", (dout == '0), 1);
    chk("rst_state", st_dbg, IDLE);
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < C; i++) begin
      if ($urandom_range(0, 3) == 0)
        addr[i*AW +: AW] = {2'(i), 18'h0, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) cs[i] = ~cs[i];
    end
    inval = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt0, cnt3;
    bit chg;
    logic f_prev;

    // 1. reset with every client requesting, then first launch
    addr[0*AW +: AW] = 22'h000100;
    addr[1*AW +: AW] = 22'h100100;
    addr[2*AW +: AW] = 22'h200100;
    addr[3*AW +: AW] = 22'h300100;
    cs = 4'hF;
    do_reset();
    tick();
    chk("rel_rd", bif.ba_rd, 1);
    chk("rel_addr", bif.ba_addr, 22'h000100);
    cs = '0;
    wait_idle(20, n);

    // 2. single miss with set ack / rdy spacing
    ack_dly = 2; rdy_dly = 3; rsp_data = 32'hDEADBEEF;
    addr[1*AW +: AW] = 22'h001234;
    cs = 4'b0010;
    tick();
    chk("miss_rd", bif.ba_rd, 1);
    chk("miss_addr", bif.ba_addr, 22'h001234);
    wait_idle(20, n);
    chk("miss_ok1", ok[1], 1);
    chk("miss_dout1", dout[1*DW +: DW], 32'hDEADBEEF);

    // 3. hit has zero latency; an address change misses again
    cs = '0; tick();
    cs = 4'b0010; #1;
    chk("hit_zero_lat", ok[1], 1);
    tick();
    chk("hit_no_req", bif.ba_rd, 0);
    addr[1*AW +: AW] = 22'h001235; #1;
    chk("addr_chg_miss", ok[1], 0);
    tick();
    chk("rereq_rd", bif.ba_rd, 1);
    chk("rereq_addr", bif.ba_addr, 22'h001235);
    cs = '0;
    wait_idle(20, n);

    // 4. round-robin order 0,2,3 then 0 again
    do_reset();
    ack_dly = 0; rdy_dly = 1;
    addr[0*AW +: AW] = {2'd0, 20'h0000A};
    addr[2*AW +: AW] = {2'd2, 20'h0000B};
    addr[3*AW +: AW] = {2'd3, 20'h0000C};
    obs_q.delete();
    chg = 0;
    cs = 4'b1101;
    for (int k = 0; k < 100 && obs_q.size() < 4; k++) begin
      if (!chg && ok[0]) begin addr[0*AW +: AW] = {2'd0, 20'h0000D}; chg = 1; end
      tick();
    end
    chk("rr_grant_cnt", obs_q.size(), 4);
    for (int k = 0; k < 4 && k < obs_q.size(); k++)
      chk($sformatf("rr_order%0d", k), obs_q[k][AW-1 -: 2], rr_order[k]);
    cs = '0;
    wait_idle(20, n);

    // 5. invalidate while awaiting data
    ack_dly = 0; rdy_dly = 4;
    addr[2*AW +: AW] = {2'd2, 20'h00777};
    cs = 4'b0100;
    tick();
    chk("inv_launch", bif.ba_rd, 1);
    for (int k = 0; k < 10 && m_ph != 2; k++) tick();
    inval = 1'b1; tick(); inval = 1'b0;
    wait_idle(20, n);
    chk("inv_ok2", ok[2], 0);
    tick();
    chk("inv_rereq_rd", bif.ba_rd, 1);
    chk("inv_rereq_addr", bif.ba_addr, 22'h200777);
    wait_idle(20, n);
    chk("inv_refill", ok[2], 1);
    cs = '0;
    tick();

    // 6a. asynchronous reset while awaiting ack
    ack_dly = 10;
    addr[0*AW +: AW] = 22'h000ABC;
    cs = 4'b0001;
    tick();
    chk("pre_rst_rd", bif.ba_rd, 1);
    tick();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_rd", bif.ba_rd, 0);
    chk("async_rst_ok", ok, 0);
    chk("async_rst_state", st_dbg, IDLE);
    cs = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // 6b. ack and rdy in the same cycle
    ack_dly = 1; rdy_dly = 0; rsp_data = 32'hA5A5_0F0F;
    addr[3*AW +: AW] = {2'd3, 20'h00333};
    cs = 4'b1000;
    tick();
    wait_idle(10, n);
    chk("ackrdy_steps", n, 2);
    chk("ackrdy_ok3", ok[3], 1);
    chk("ackrdy_dout3", dout[3*DW +: DW], 32'hA5A5_0F0F);
    chk("ackrdy_state", st_dbg, IDLE);
    cs = '0;
    tick();

    // random traffic
    noise = 1; rand_dly = 1;
    for (int k = 0; k < 2000; k++) begin
      rand_inputs();
      tick();
    end
    noise = 0; rand_dly = 0; inval = 1'b0; cs = '0;
    tick();
    wait_idle(20, n);
    chk("drain", exp_q.size(), 0);

    // fixed priority: client 0 always missing starves client 3
    cnt0 = 0; cnt3 = 0; f_prev = fif.ba_rd;
    f_addr[3*AW +: AW] = {2'd3, 20'h00005};
    f_cs = 4'b1001;
    for (int k = 0; k < 80; k++) begin
      f_addr[0*AW +: AW] = {2'd0, 20'(k)};
      tick();
      if (fif.ba_rd && !f_prev) begin
        if (fif.ba_addr[AW-1 -: 2] == 2'd3) cnt3++;
        else cnt0++;
      end
      f_prev = fif.ba_rd;
    end
    chk("fix_starve3", cnt3, 0);
    chk("fix_grants0", (cnt0 >= 10), 1);
    f_cs = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtframe_rom_arb.md
Name: jtframe_rom_arb

Overview:
- Parametrised N-client read arbiter for one read-only SDRAM bank port; successor to the fixed one-client-per-bank ba1..ba3 hookup.
- Lets several game-side ROM clients share one bank.
- Each client has a one-entry cache (tag, data, valid), so a repeated address is served without an SDRAM access.
- Sits between the game ROM clients and the baN_addr/baN_rd/baN_ack/baN_rdy port of the SDRAM controller, in the clk_rom domain.

Parameters:
CLIENTS, 4, number of client ports (2..8)
AW, 22, address width (matches SDRAMW)
DW, 32, data width (matches sdram_dout)
MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk_rom  in  1  SDRAM-domain clock; all logic is rising-edge
rst_n  in  1  asynchronous reset, active low
cs  in  CLIENTS  per-client read request, level
addr  in  CLIENTS*AW  client i address in bits [i*AW +: AW]
ok  out  CLIENTS  dout for client i is valid for the current addr
dout  out  CLIENTS*DW  client i data in bits [i*DW +: DW]
inval  in  1  invalidate all cache entries (pulse or level)
ba_addr  out  AW  bank address
ba_rd  out  1  bank read request
ba_ack  in  1  controller accepted the request
ba_rdy  in  1  sdram_dout is valid this cycle
sdram_dout  in  DW  bank read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - all valid bits = 0, tags = 0, data = 0
  - ok = 0, dout = 0
  - ba_rd = 0, ba_addr = 0
  - state = IDLE, rr pointer = 0, drop flag = 0
- Hit and miss per client i:
  - hit[i] = cs[i] & valid[i] & (tag[i] == addr[i])
  - ok[i] = hit[i], combinational from registered state; a hit has zero latency
  - miss[i] = cs[i] & ~hit[i]
  - dout[i] always drives data[i], even when ok[i] = 0
- FSM states: IDLE, WAIT_ACK, WAIT_RDY.
- IDLE:
  - If any miss, the picker selects client sel:
    - MODE 0: lowest index with miss
    - MODE 1: first index with miss at or after rr, wrapping modulo CLIENTS
  - Register sel and lat_addr = addr[sel]; ba_addr = addr[sel], ba_rd = 1; next state WAIT_ACK.
  - No miss: ba_rd = 0, stay in IDLE.
  - ba_ack or ba_rdy arriving while in IDLE is ignored.
- WAIT_ACK:
  - ba_rd and ba_addr held stable until ba_ack is sampled high.
  - On ack: ba_rd = 0 next cycle; next state WAIT_RDY.
  - If ba_ack and ba_rdy are high in the same cycle, perform the WAIT_RDY completion directly and return to IDLE.
- WAIT_RDY, on ba_rdy:
  - If drop = 0: data[sel] = sdram_dout, tag[sel] = lat_addr, valid[sel] = 1.
  - If drop = 1: nothing is stored.
  - drop = 0; rr = sel+1 (wraps to 0 after CLIENTS-1); next state IDLE.
- Minimum miss latency:
  - ba_rd rises 1 cycle after the miss appears.
  - ok rises 1 cycle after ba_rdy, if addr is unchanged.
  - Back-to-back requests are separated by one IDLE cycle.
- Client address changes while its request is in flight: the returned data is stored under lat_addr; ok follows only when addr matches the tag. No abort is issued to the SDRAM.
- cs deasserted mid-flight: the transaction still completes and the entry is filled.
- inval high in any cycle:
  - clears all valid bits that cycle
  - if state != IDLE, sets drop so the in-flight result is discarded
  - a miss still launches from IDLE while inval is high
- Starvation: MODE 0 may starve high indices (documented, not prevented). MODE 1 bounds any client's wait to CLIENTS-1 transactions.

Decomposition:
- Package jtframe_arb_pkg holds:
  - state enum arb_st_t {IDLE, WAIT_ACK, WAIT_RDY}
  - localparams ARB_FIXED = 0, ARB_RR = 1
  - function clog2w used for the sel/rr width
- Sub-module jtframe_arb_pick: combinational picker.
  - Inputs: req[CLIENTS], rr pointer, mode.
  - Outputs: sel index, any.
  - Unit-testable on its own.

Test Plan:
1. Reset: hold rst_n = 0 with cs = 4'hF -> ok = 0, ba_rd = 0, dout = 0. Release reset -> ba_rd = 1 next cycle, ba_addr = addr[0].
2. Single miss: cs[1] = 1, addr1 = 22'h01234; ba_ack 2 cycles after ba_rd; ba_rdy with sdram_dout = 32'hDEADBEEF 3 cycles later -> dout1 = DEADBEEF and ok[1] = 1 the cycle after ba_rdy; ba_rd low from the cycle after ack.
3. Hit: keep addr1 = 22'h01234 after scenario 2 and toggle cs[1] -> ok[1] = 1 in the same cycle, ba_rd stays 0. Change addr1 to 22'h01235 -> ok[1] = 0 and a new request goes out.
4. Round-robin, MODE = 1: clients 0, 2, 3 miss simultaneously with rr = 0 -> service order 0, 2, 3. Client 0 re-misses after 2 -> order 0, 2, 3, 0. With MODE = 0 and client 0 missing continuously on new addresses -> client 3 never granted.
5. Invalidate in flight: pulse inval during WAIT_RDY for client 2 -> after ba_rdy, valid[2] = 0 and ok[2] = 0, and client 2 is re-requested from IDLE.
6. Reset mid-operation plus simultaneous events: assert rst_n = 0 in WAIT_ACK -> ba_rd drops asynchronously and all ok = 0. Separately, ba_ack and ba_rdy in the same cycle -> entry filled and state returns to IDLE in one step.
